s2p_deser: RTL and testbench
============================

# s2p_deser

Parametrised serial-to-parallel deserializer: the successor to the fixed 8-bit converter. It assembles WIDTH serial bits into a parallel word, with selectable bit order and per-bit qualification. The word is held in a one-entry output buffer drained by a valid/ready handshake. It sits between a serial front end (shift source, UART-style sampler) and a parallel consumer that may stall.

## Interface
- WIDTH, 8: data bits per frame, 2..32.
- MSB_FIRST, 0: 0 = first received bit lands in a[0]; 1 = first bit lands in a[WIDTH-1].
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- serial_start  in  1  frame start; d in this cycle is bit 0 of the frame.
- d  in  1  serial data.
- d_valid  in  1  qualifies d for bits 1..WIDTH-1 (and parity); ignored in the serial_start cycle.
- busy  out  1  frame in progress (state SHIFT or PARITY).
- end_conversion  out  1  one-cycle pulse, frame completed and accepted into the buffer.
- out_valid  out  1  buffer holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- a  out  WIDTH  parallel word; stable while out_valid.
- overrun  out  1  sticky: a completed frame was dropped because the buffer was full.
- parity_err  out  1  present only with S2P_PARITY_EN; see Configuration.

## Operation
- States: IDLE, SHIFT, PARITY (only with S2P_PARITY_EN).
- IDLE: serial_start=1 → capture d as bit 0, bit counter = 1, → SHIFT. Other inputs are ignored.
- SHIFT: each cycle with d_valid=1 captures d at index cnt (LSB-first) or WIDTH-1-cnt (MSB-first), then cnt+1. A cycle with d_valid=0 holds state. When the bit with cnt==WIDTH-1 is captured → complete frame (→ IDLE), or → PARITY with S2P_PARITY_EN.
- PARITY: a d_valid cycle samples the parity bit, completes the frame and → IDLE.
- serial_start in SHIFT/PARITY aborts the partial frame without error and restarts with the current d as bit 0. Priority: serial_start > d_valid.
- Counter is $clog2(WIDTH)+1 bits and never wraps; shift register is separate from a.
- Frame completion:
  - Buffer empty, or out_ready=1 in the same cycle: a ← assembled word, out_valid=1, end_conversion pulses.
  - Buffer full and out_ready=0: word dropped, overrun ← 1, a and out_valid unchanged, no end_conversion.
- Handshake: out_valid falls the cycle after out_valid && out_ready unless a new word loads on that same edge. out_valid is never withdrawn without a handshake.
- overrun clears only on rst.
- Reset values: state IDLE, cnt 0, busy 0, end_conversion 0, out_valid 0, a 0, overrun 0, parity_err 0. Reset mid-frame discards everything.

## Timing
- serial_start at cycle 0 plus d_valid on cycles 1..WIDTH-1 (contiguous) gives a/out_valid/end_conversion visible after the edge ending cycle WIDTH-1. Latency is one cycle after the last bit; PARITY adds one qualified cycle.
- end_conversion, out_valid and a are registered outputs; there is no combinational path from d.
- Back-to-back frames: serial_start may be asserted in the cycle after the last bit (IDLE) or in the last-bit cycle itself. In the last-bit cycle it takes priority and aborts that frame.
- Throughput: one word per WIDTH cycles with out_ready held high.

## Configuration
- S2P_PARITY_EN defined:
  - Adds state PARITY and output parity_err.
  - Expected even parity: XOR of the WIDTH data bits and the parity bit equals 0.
  - parity_err is registered alongside a, valid while out_valid, and updated on each word load.
  - A parity-failing word is still delivered.
- Undefined: no PARITY state, no parity_err port, and the frame completes on data bit WIDTH-1.

## Test plan
- WIDTH=8, LSB-first: serial_start with d=1, then d_valid bits 1,0,1,1,0,0,1 → a=8'h9B (bits 1,1,0,1,1,0,0,1 from bit0), out_valid=1, one end_conversion pulse.
- WIDTH=8, MSB_FIRST=1, same bit stream → a=8'hD9; d_valid gaps of 3 cycles mid-frame → same result, latency extended by 3.
- out_ready=0, two full frames → first word (8'h9B) retained, overrun=1, second word absent. Then out_ready=1 → out_valid=0 the next cycle, overrun stays 1.
- Abort: serial_start at bit 4, then a fresh 8-bit frame 8'h3C → a=8'h3C, single end_conversion, overrun=0.
- rst pulse at bit 5 of a frame, asynchronous mid-cycle → all outputs 0 immediately. The next frame 8'hA5 converts normally.
- S2P_PARITY_EN, WIDTH=8: data 8'h9B with parity bit 1 → parity_err=0; same data with parity bit 0 → parity_err=1, a=8'h9B still delivered.

Source files
------------

// File: rtl/s2p_deser.sv
// s2p_deser: parametrised serial-to-parallel deserializer with a one-entry
// valid/ready output buffer, selectable bit order and sticky overrun flag.
// Optional feature macro: S2P_PARITY_EN (adds PARITY state and parity_err).
module s2p_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_start,
  input  logic             d,
  input  logic             d_valid,
  output logic             busy,
  output logic             end_conversion,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic             overrun
`ifdef S2P_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int unsigned     CW        = $clog2(WIDTH) + 1;
  localparam int unsigned     START_IDX = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CW-1:0]   LAST      = CW'(WIDTH - 1);

`ifdef S2P_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next, idx;
  logic [WIDTH-1:0] shreg, shreg_next, word;
  logic             done;
  logic             load;
`ifdef S2P_PARITY_EN
  logic             perr_next;
`endif

  // Bit position for the current capture depends on the configured order.
  assign idx  = MSB_FIRST ? (LAST - cnt) : cnt;
  // A finished frame is taken when the buffer is free or drains on this edge.
  assign load = done && (!out_valid || out_ready);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, capture and frame-completion logic; serial_start wins over d_valid.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
    done       = 1'b0;
    word       = shreg;
`ifdef S2P_PARITY_EN
    perr_next  = 1'b0;
`endif
    if (serial_start) begin
      shreg_next            = '0;
      shreg_next[START_IDX] = d;
      cnt_next              = CW'(1);
      state_next            = SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          if (d_valid) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              if (CW'(i) == idx) shreg_next[i] = d;
            end
            cnt_next = cnt + CW'(1);
            if (cnt == LAST) begin
`ifdef S2P_PARITY_EN
              state_next = PARITY;
`else
              done       = 1'b1;
              word       = shreg_next;
              state_next = IDLE;
              cnt_next   = '0;
`endif
            end
          end
        end
`ifdef S2P_PARITY_EN
        PARITY: begin
          if (d_valid) begin
            done       = 1'b1;
            word       = shreg;
            perr_next  = (^shreg) ^ d;
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Shift register, bit counter and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      shreg <= shreg_next;
      cnt   <= cnt_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Output buffer: load on completion, drain on handshake, flag dropped frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a              <= '0;
      out_valid      <= 1'b0;
      end_conversion <= 1'b0;
      overrun        <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_err     <= 1'b0;
`endif
    end else begin
      end_conversion <= load;
      if (load) begin
        a         <= word;
        out_valid <= 1'b1;
`ifdef S2P_PARITY_EN
        parity_err <= perr_next;
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (done && !load) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_s2p_deser.sv
// tb_s2p_deser: scoreboard bench for s2p_deser, LSB-first and MSB-first
// instances driven by the same serial stream. Honours S2P_PARITY_EN.
module tb_s2p_deser;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, serial_start, d, d_valid, out_ready;
  logic         busy_l, eoc_l, ov_l, ovr_l;
  logic         busy_m, eoc_m, ov_m, ovr_m;
  logic [W-1:0] a_l, a_m;
`ifdef S2P_PARITY_EN
  logic         perr_l, perr_m;
`endif

  int checks = 0;
  int errors = 0;
  int eoc_cnt_l = 0;
  int eoc_cnt_m = 0;
  int loads = 0;

  typedef struct packed {
    logic [W-1:0] w;
    logic         pe;
  } exp_t;

  exp_t q_l[$];
  exp_t q_m[$];
  exp_t e_l, e_m;

  always #5 clk = ~clk;

  s2p_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .serial_start(serial_start), .d(d), .d_valid(d_valid),
    .busy(busy_l), .end_conversion(eoc_l), .out_valid(ov_l), .out_ready(out_ready),
    .a(a_l), .overrun(ovr_l)
`ifdef S2P_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

  s2p_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .serial_start(serial_start), .d(d), .d_valid(d_valid),
    .busy(busy_m), .end_conversion(eoc_m), .out_valid(ov_m), .out_ready(out_ready),
    .a(a_m), .overrun(ovr_m)
`ifdef S2P_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // LSB-first monitor: every end_conversion must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && eoc_l) begin
      eoc_cnt_l++;
      if (q_l.size() == 0) check("eoc_unexpected_lsb", 32'(1), 32'(0));
      else begin
        e_l = q_l.pop_front();
        check("a_lsb", 32'(a_l), 32'(e_l.w));
`ifdef S2P_PARITY_EN
        check("perr_lsb", 32'(perr_l), 32'(e_l.pe));
`endif
      end
    end
  end

  // MSB-first monitor.
  always @(negedge clk) begin
    if (!rst && eoc_m) begin
      eoc_cnt_m++;
      if (q_m.size() == 0) check("eoc_unexpected_msb", 32'(1), 32'(0));
      else begin
        e_m = q_m.pop_front();
        check("a_msb", 32'(a_m), 32'(e_m.w));
`ifdef S2P_PARITY_EN
        check("perr_msb", 32'(perr_m), 32'(e_m.pe));
`endif
      end
    end
  end

  // Sends w bit 0 first; optional d_valid gap before bit 4; expects load or drop.
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit ld, input bit bad_par);
    if (ld) begin
      q_l.push_back({w, bad_par});
      q_m.push_back({rev(w), bad_par});
      loads++;
    end
    serial_start = 1'b1;
    d            = w[0];
    d_valid      = 1'($urandom);
    step();
    serial_start = 1'b0;
    check("busy_after_start", 32'(busy_l), 32'(1));
    for (int i = 1; i < W; i++) begin
      if (i == 4 && gap > 0) begin
        d_valid = 1'b0;
        d       = ~w[4];
        repeat (gap) step();
        check("busy_gap", 32'(busy_m), 32'(1));
        check("eoc_gap", 32'(eoc_l), 32'(0));
      end
      d_valid = 1'b1;
      d       = w[i];
      step();
    end
`ifdef S2P_PARITY_EN
    d_valid = 1'b1;
    d       = (^w) ^ bad_par;
    step();
`endif
    d_valid = 1'b0;
    d       = 1'b0;
    check("eoc_lsb_done", 32'(eoc_l), 32'(ld));
    check("eoc_msb_done", 32'(eoc_m), 32'(ld));
    check("out_valid_done", 32'(ov_l), 32'(1));
    check("busy_done", 32'(busy_l), 32'(0));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    serial_start = 1'b0;
    d            = 1'b0;
    d_valid      = 1'b0;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_l), 32'(0));
    check("rst_eoc", 32'(eoc_l), 32'(0));
    check("rst_out_valid", 32'(ov_l), 32'(0));
    check("rst_a_lsb", 32'(a_l), 32'(0));
    check("rst_a_msb", 32'(a_m), 32'(0));
    check("rst_overrun", 32'(ovr_l), 32'(0));
`ifdef S2P_PARITY_EN
    check("rst_perr", 32'(perr_l), 32'(0));
`endif
    rst = 1'b0;
    step();

    // Basic frame, then handshake drains the buffer.
    send_word(8'h9B, 0, 1'b1, 1'b0);
    step();
    check("out_valid_drained", 32'(ov_l), 32'(0));
    check("a_held_after_drain", 32'(a_l), 32'(8'h9B));

    // Gapped frame, then back-to-back frames.
    send_word(8'h9B, 3, 1'b1, 1'b0);
    send_word(8'h3C, 0, 1'b1, 1'b0);
    send_word(8'hE1, 0, 1'b1, 1'b0);
`ifdef S2P_PARITY_EN
    send_word(8'h9B, 0, 1'b1, 1'b1);
    send_word(8'h9B, 0, 1'b1, 1'b0);
`endif
    step();
    step();

    // Stalled consumer: second frame dropped, overrun set.
    out_ready = 1'b0;
    send_word(8'h9B, 0, 1'b1, 1'b0);
    send_word(8'h5A, 0, 1'b0, 1'b0);
    check("overrun_lsb", 32'(ovr_l), 32'(1));
    check("overrun_msb", 32'(ovr_m), 32'(1));
    check("a_retained_lsb", 32'(a_l), 32'(8'h9B));
    check("a_retained_msb", 32'(a_m), 32'(8'hD9));
    out_ready = 1'b1;
    step();
    check("out_valid_after_ready", 32'(ov_l), 32'(0));
    check("overrun_sticky", 32'(ovr_l), 32'(1));

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("overrun_cleared", 32'(ovr_l), 32'(0));

    // Abort at bit 4 by a fresh serial_start.
    serial_start = 1'b1;
    d            = 1'b1;
    step();
    serial_start = 1'b0;
    d_valid      = 1'b1;
    for (int i = 1; i < 4; i++) begin
      d = 1'($urandom);
      step();
    end
    send_word(8'h3C, 0, 1'b1, 1'b0);
    check("abort_overrun", 32'(ovr_l), 32'(0));

    // Abort in the last-bit cycle.
    serial_start = 1'b1;
    d            = 1'b0;
    step();
    serial_start = 1'b0;
    d_valid      = 1'b1;
    for (int i = 1; i < W - 1; i++) begin
      d = 1'($urandom);
      step();
    end
    send_word(8'h66, 0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of bit 5.
    serial_start = 1'b1;
    d            = 1'b1;
    step();
    serial_start = 1'b0;
    d_valid      = 1'b1;
    for (int i = 1; i < 5; i++) begin
      d = 1'($urandom);
      step();
    end
    d = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy_l), 32'(0));
    check("arst_out_valid", 32'(ov_l), 32'(0));
    check("arst_a", 32'(a_l), 32'(0));
    check("arst_eoc", 32'(eoc_m), 32'(0));
    d_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    send_word(8'hA5, 0, 1'b1, 1'b0);

    repeat (3) step();
    check("queue_lsb_empty", 32'(q_l.size()), 32'(0));
    check("queue_msb_empty", 32'(q_m.size()), 32'(0));
    check("eoc_count_lsb", 32'(eoc_cnt_l), 32'(loads));
    check("eoc_count_msb", 32'(eoc_cnt_m), 32'(loads));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
